// File: rtl/key_debounce_multi_pkg.sv
// Shared types for the multi-key debouncer: FSM state encoding, per-channel
// event bundle and a constant-evaluable clog2.
package key_debounce_multi_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic long_hit;
    } key_evt_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input longint v);
        int r;
        r = 0;
        for (int i = 0; i < 62; i++) begin
            if ((longint'(1) << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, debounce FSM, hold counter and registered
// level/press/release/long-press outputs.
module key_debounce_channel
    import key_debounce_multi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     pin,
    output key_evt_t evt
);

    localparam int CNT_W    = clog2(longint'(DEBOUNCE_CYCLES));
    localparam int HOLD_RAW = clog2(longint'(LONG_CYCLES) + 1);
    localparam int HOLD_W   = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
    localparam bit LONG_EN  = (LONG_CYCLES != 0);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = LONG_EN ? HOLD_W'(LONG_CYCLES - 1) : '0;
    localparam logic              PIN_IDLE  = ACTIVE_LOW;

    logic [1:0]        sync;
    logic              p;
    key_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;

    // Normalised pressed indication, independent of pin polarity.
    assign p = ACTIVE_LOW ? ~sync[1] : sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= {2{PIN_IDLE}};
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
            evt   <= '0;
        end else begin
            sync         <= {sync[0], pin};
            evt.press    <= 1'b0;
            evt.rel      <= 1'b0;
            evt.long_hit <= 1'b0;

            case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        evt.press <= 1'b1;
                        evt.level <= 1'b1;
                        hold      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!p) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (LONG_EN) begin
                        // Saturating hold means the pulse can only fire once per hold.
                        if (hold == HOLD_LAST) evt.long_hit <= 1'b1;
                        if (hold != HOLD_MAX) hold <= hold + 1'b1;
                    end
                end

                RELEASE_WAIT: begin
                    // A short glitch returns to PRESSED with hold intact.
                    if (p) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        evt.rel   <= 1'b1;
                        evt.level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: independent channel instances whose
// registered outputs are gathered into per-function bit vectors.
module key_debounce_multi
    import key_debounce_multi_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [N_KEYS-1:0] Pin_In,
    output logic [N_KEYS-1:0] Key_Level,
    output logic [N_KEYS-1:0] Press_Pulse,
    output logic [N_KEYS-1:0] Release_Pulse,
    output logic [N_KEYS-1:0] Long_Pulse
);

    key_evt_t [N_KEYS-1:0] evt;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk   (CLK),
            .rst_n (RST_n),
            .pin   (Pin_In[g]),
            .evt   (evt[g])
        );

        assign Key_Level[g]     = evt[g].level;
        assign Press_Pulse[g]   = evt[g].press;
        assign Release_Pulse[g] = evt[g].rel;
        assign Long_Pulse[g]    = evt[g].long_hit;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench: stimulus pushes expected pulse events; monitors pop and
// compare whenever a DUT raises any pulse. A second DUT has long-press off.
module tb_key_debounce_multi;

    localparam int NK = 2;
    localparam int DB = 8;
    localparam int LC = 20;
    localparam int LAT = DB + 3;  // drive cycle -> pulse cycle

    typedef struct {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lg;
        logic [1:0] lv;
    } ev_t;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic [NK-1:0] Pin_In = 2'b11;
    logic [NK-1:0] Key_Level, Press_Pulse, Release_Pulse, Long_Pulse;
    logic [NK-1:0] lvl0, pr0, rl0, lg0;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t q[$];
    ev_t q0[$];
    ev_t em, em0;

    key_debounce_multi #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b1)) dut (
        .CLK(CLK), .RST_n(RST_n), .Pin_In(Pin_In), .Key_Level(Key_Level),
        .Press_Pulse(Press_Pulse), .Release_Pulse(Release_Pulse), .Long_Pulse(Long_Pulse)
    );

    key_debounce_multi #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(0), .ACTIVE_LOW(1'b1)) dut0 (
        .CLK(CLK), .RST_n(RST_n), .Pin_In(Pin_In), .Key_Level(lvl0),
        .Press_Pulse(pr0), .Release_Pulse(rl0), .Long_Pulse(lg0)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic exp_ev(input int c, input logic [1:0] pr, input logic [1:0] rl,
                          input logic [1:0] lg, input logic [1:0] lv);
        ev_t e;
        e = '{c, pr, rl, lg, lv};
        q.push_back(e);
        if (|{pr, rl}) begin
            e.lg = 2'b00;
            q0.push_back(e);
        end
    endtask

    task automatic cmp(input string nm, input ev_t e, input int c, input logic [1:0] pr,
                       input logic [1:0] rl, input logic [1:0] lg, input logic [1:0] lv);
        checks++;
        if (c != e.cyc || pr != e.pr || rl != e.rl || lg != e.lg || lv != e.lv) begin
            errors++;
            $display("FAIL %s event: got cyc=%0d pr=%b rl=%b lg=%b lv=%b, want cyc=%0d pr=%b rl=%b lg=%b lv=%b",
                     nm, c, pr, rl, lg, lv, e.cyc, e.pr, e.rl, e.lg, e.lv);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %b, want %b", nm, cyc, got, want);
        end
    endtask

    always @(negedge CLK) begin
        if (|{Press_Pulse, Release_Pulse, Long_Pulse}) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut unexpected event at cyc %0d: pr=%b rl=%b lg=%b, want none",
                         cyc, Press_Pulse, Release_Pulse, Long_Pulse);
            end else begin
                em = q.pop_front();
                cmp("dut", em, cyc, Press_Pulse, Release_Pulse, Long_Pulse, Key_Level);
            end
        end
        if (|{pr0, rl0, lg0}) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected event at cyc %0d: pr=%b rl=%b lg=%b, want none",
                         cyc, pr0, rl0, lg0);
            end else begin
                em0 = q0.pop_front();
                cmp("dut0", em0, cyc, pr0, rl0, lg0, lvl0);
            end
        end
    end

    initial begin
        // Reset state
        tick(3);
        chk("reset_dut", {Key_Level, Press_Pulse, Release_Pulse, Long_Pulse}, 8'h00);
        chk("reset_dut0", {lvl0, pr0, rl0, lg0}, 8'h00);
        RST_n = 1'b1;
        tick(5);

        // Clean press, long press, release on key 0
        Pin_In = 2'b10;
        exp_ev(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        exp_ev(cyc + LAT + LC, 2'b00, 2'b00, 2'b01, 2'b01);
        tick(LAT + 40);
        chk("long_hold_level", {6'd0, Key_Level}, 8'h01);
        Pin_In = 2'b11;
        exp_ev(cyc + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        tick(LAT + 4);

        // Bounce with 5-clock low periods is rejected
        for (int i = 0; i < 3; i++) begin
            Pin_In = 2'b10;
            tick(5);
            Pin_In = 2'b11;
            tick(5);
        end
        chk("bounce_level", {6'd0, Key_Level}, 8'h00);
        Pin_In = 2'b10;
        exp_ev(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        tick(LAT + 2);

        // 3-clock release glitch while pressed
        Pin_In = 2'b11;
        tick(3);
        Pin_In = 2'b10;
        for (int i = 0; i < 8; i++) begin
            chk("glitch_level", {6'd0, Key_Level}, 8'h01);
            tick(1);
        end
        Pin_In = 2'b11;
        exp_ev(cyc + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        tick(LAT + 4);

        // Simultaneous press, then reset mid-hold
        Pin_In = 2'b00;
        exp_ev(cyc + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        tick(LAT + 5);
        RST_n = 1'b0;
        tick(1);
        chk("midreset_dut", {Key_Level, Press_Pulse, Release_Pulse, Long_Pulse}, 8'h00);
        chk("midreset_dut0", {lvl0, pr0, rl0, lg0}, 8'h00);
        RST_n = 1'b1;
        exp_ev(cyc + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        tick(LAT + 5);
        Pin_In = 2'b11;
        exp_ev(cyc + LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        tick(LAT + 4);

        // 100-clock hold: long pulse only where long-press is enabled
        Pin_In = 2'b10;
        exp_ev(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        exp_ev(cyc + LAT + LC, 2'b00, 2'b00, 2'b01, 2'b01);
        tick(100);
        chk("hold100_level_dut0", {6'd0, lvl0}, 8'h01);
        Pin_In = 2'b11;
        exp_ev(cyc + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        tick(LAT + 6);

        chk("dut_missing_events", 8'(q.size()), 8'd0);
        chk("dut0_missing_events", 8'(q0.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button debouncer; successor to the single-key debouncer.
- Each channel synchronises a raw pin, filters bounce with a configurable qualification time, and reports state as a level.
- Reports events as single-cycle pulses: press, release, and one-shot long-press.
- Sits between board key pins and application control logic (mode FSMs, counters, LED sequencers).

Parameters:
- N_KEYS, 4, number of independent key channels (>=1).
- DEBOUNCE_CYCLES, 1000000, clocks a level must be stable to qualify (20 ms at 50 MHz); >=2.
- LONG_CYCLES, 50000000, clocks of qualified hold before the long-press pulse (1 s at 50 MHz); 0 disables long-press.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  synchronous active-low reset.
- Pin_In  in  N_KEYS  raw asynchronous key pins.
- Key_Level  out  N_KEYS  debounced level, 1 = pressed.
- Press_Pulse  out  N_KEYS  one-clock pulse on qualified press.
- Release_Pulse  out  N_KEYS  one-clock pulse on qualified release.
- Long_Pulse  out  N_KEYS  one-clock pulse once per hold reaching LONG_CYCLES.

Behaviour:
- Channels are fully independent; no cross-channel priority or interaction.
- Synchroniser per channel:
  - Two flip-flops.
  - Reset value = released pin level (ACTIVE_LOW ? 1 : 0).
  - Output normalised to p (1 = pressed).
- Counters:
  - Debounce counter width = clog2(DEBOUNCE_CYCLES).
  - Hold counter width = clog2(LONG_CYCLES+1).
  - Neither counter wraps.
- FSM states and transitions, per channel:
  - IDLE: p=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - p=0 -> IDLE, no pulse.
    - p=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; Press_Pulse<=1 for one clock; hold<=0.
    - Otherwise cnt++.
  - PRESSED:
    - p=0 -> RELEASE_WAIT, cnt<=0.
    - Otherwise, if LONG_CYCLES!=0, hold increments and saturates at LONG_CYCLES.
    - Long_Pulse<=1 for one clock on the edge where hold reaches LONG_CYCLES-1 and p=1.
  - RELEASE_WAIT:
    - p=1 -> PRESSED; no new Press_Pulse; hold preserved.
    - p=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; Release_Pulse<=1 for one clock.
    - Otherwise cnt++.
- Key_Level = 1 in PRESSED or RELEASE_WAIT; registered.
- Latency: if pin changes before edge k (and stays stable), the pulse is high during the cycle after edge k+DEBOUNCE_CYCLES+2. This holds for press and release.
- Long_Pulse fires at most once per hold. It can fire even if the hold is interrupted only by bounce shorter than DEBOUNCE_CYCLES.
- Press_Pulse and Release_Pulse of one channel are never high in the same cycle.
- Reset:
  - Every output is 0, all FSMs are IDLE, all counters are 0.
  - Reset asserted mid-press takes effect at the next edge.
  - A key held through reset release produces a fresh Press_Pulse DEBOUNCE_CYCLES+3 edges after reset deasserts.
- All outputs are registered; no combinational path from Pin_In to any output.

Decomposition:
- Shared package: state encoding constants (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and a clog2 helper function.
- One sub-module, key_debounce_channel: synchroniser, FSM and counters for one key.
- Top instantiates it N_KEYS times via generate and concatenates outputs.

Test Plan:
- Bench parameters: N_KEYS=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=20, ACTIVE_LOW=1.
- Clean press: Pin_In[0] 1->0 and held -> Press_Pulse[0] single cycle, 10 edges after the sample edge (8+2). Key_Level[0] rises the same cycle. Channel 1 stays silent.
- Bounce rejection: Pin_In[0] toggles with low periods of 5 clocks -> no pulses, Key_Level stays 0. A final stable low -> exactly one Press_Pulse.
- Long press: hold 40 clocks after Press_Pulse -> exactly one Long_Pulse, 20 clocks after Press_Pulse. Then release -> one Release_Pulse, 10 clocks later.
- Release bounce: while pressed, high glitch of 3 clocks -> no Release_Pulse, no second Press_Pulse, Key_Level stays 1.
- Simultaneous and reset: both keys pressed on the same edge -> both Press_Pulse bits high in the same cycle. Then RST_n=0 for 1 clock mid-hold -> all outputs 0 next cycle. With the key still held, Press_Pulse reappears 11 edges after reset release.
- LONG_CYCLES=0 rerun: a 100-clock hold gives Long_Pulse never asserted; press and release pulses are unchanged.
